backward_sequencer: RTL and testbench
=====================================

Name: backward_sequencer

Overview:
- Control FSM that sequences one DQN backward pass over the Backward datapath.
- Latches the transition (act, st, st1) on a start request, then drives the `controller` phase code through Qt, reward/dadz/maxQt1, delta3, delta2 and gradient phases.
- Each phase is held for a programmable number of cycles; the block pulses `done` at the end.
- Maintains the episode `step` counter consumed by reward_module, dadz_module and delta*_module.

Parameters:
- PH_LEN, 2: cycles each active phase is held (legal 1..15).
- MAX_STEP, 16: `step` wraps to 0 after MAX_STEP-1 (legal 2..16).
- GOAL_ST, 15: state code marking episode end.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request one backward pass; sampled in IDLE only.
- act_in  in  2  action taken.
- st_in  in  4  current state.
- st1_in  in  4  next state.
- stall  in  1  freeze sequencing (only with BWD_STALL_EN).
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle pulse, pass complete.
- grad_valid  out  1  high on the final cycle of the GRAD phase.
- controller  out  4  phase code to datapath.
- step  out  4  episode step counter.
- act  out  2  latched action.
- st  out  4  latched st.
- st1  out  4  latched st1.

Behaviour:
- Reset (rst=0, async) clears all state and forces every output to 0: busy, done, grad_valid, controller, step, act, st, st1; FSM goes to IDLE. A reset during a pass aborts it with no done pulse, and step is not incremented.
- FSM states and controller codes: IDLE=0, QT=1, MAXQ=6, DELTA3=7, DELTA2=8, GRAD=9, DONE=10.
- IDLE:
  - If start=1 at edge k, latch act_in, st_in and st1_in into act, st and st1.
  - Clear the phase counter and enter QT; controller=1 from cycle k+1.
  - If start=0, stay in IDLE.
- start while busy=1 is ignored; it is neither queued nor does it relatch inputs.
- Each active state (QT, MAXQ, DELTA3, DELTA2, GRAD) lasts exactly PH_LEN cycles:
  - A 4-bit phase counter counts 0..PH_LEN-1.
  - At PH_LEN-1 the counter resets to 0 and the FSM advances QT -> MAXQ -> DELTA3 -> DELTA2 -> GRAD -> DONE.
- grad_valid = 1 only while state=GRAD and phase counter = PH_LEN-1.
- DONE lasts exactly 1 cycle:
  - done=1, controller=10, busy=1.
  - Next state is IDLE unconditionally; start is not sampled in DONE.
- Latency: done is high in cycle k+1+5*PH_LEN after the start edge k (cycle k+11 with PH_LEN=2). Earliest next accepted start is cycle k+2+5*PH_LEN.
- step update, applied on the DONE->IDLE edge:
  - If latched st1==GOAL_ST, step becomes 0 (episode end; takes priority).
  - Else if step==MAX_STEP-1, step becomes 0 (wrap).
  - Otherwise step increments by 1.
- step, act, st and st1 are stable for the whole pass; the datapath samples them freely.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: BWD_STALL_EN.
- Defined: while stall=1 in any active state, the phase counter, FSM state, controller and grad_valid hold their values. stall in IDLE or DONE has no effect, so a pass always completes once DONE is reached. Total latency grows by the number of stalled cycles.
- Undefined: the stall port still exists but is ignored; timing is fixed as above.

Test Plan:
- Reset then idle: rst=0 pulse mid-idle, then start=0 for 20 cycles -> all outputs 0, busy=0 throughout.
- Single pass, PH_LEN=2: start at edge 0 with act_in=2, st_in=3, st1_in=4:
  - controller=1,1,6,6,7,7,8,8,9,9,10 on cycles 1..11.
  - grad_valid on cycle 10; done on cycle 11.
  - act/st/st1 = 2/3/4; step goes 0->1 after cycle 11.
- Busy rejection: start held high continuously with changing st_in -> st latched only at accepted starts; done every 12 cycles; no early phase change.
- Step wrap and goal: MAX_STEP=4, four passes with st1_in=5 -> step sequence 1,2,3,0. Then a pass with step=2 and st1_in=15 -> step=0.
- Mid-pass reset: assert rst=0 during DELTA3 -> outputs 0 immediately (async), no done pulse, step unchanged at 0. A new start then completes normally.
- Stall (BWD_STALL_EN): stall=1 for 3 cycles during MAXQ -> controller stays 6 for 5 cycles; done arrives at cycle 14 instead of 11.

Source files
------------

// File: rtl/backward_sequencer.sv
// Control FSM sequencing one DQN backward pass: Qt, maxQt1, delta3, delta2 and gradient phases.
// Optional macro BWD_STALL_EN makes the stall input freeze the active phases.
module backward_sequencer #(
    parameter int PH_LEN   = 2,
    parameter int MAX_STEP = 16,
    parameter int GOAL_ST  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] act_in,
    input  logic [3:0] st_in,
    input  logic [3:0] st1_in,
    input  logic       stall,
    output logic       busy,
    output logic       done,
    output logic       grad_valid,
    output logic [3:0] controller,
    output logic [3:0] step,
    output logic [1:0] act,
    output logic [3:0] st,
    output logic [3:0] st1
);

    // State encoding doubles as the controller phase code seen by the datapath.
    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] QT     = 4'd1;
    localparam logic [3:0] MAXQ   = 4'd6;
    localparam logic [3:0] DELTA3 = 4'd7;
    localparam logic [3:0] DELTA2 = 4'd8;
    localparam logic [3:0] GRAD   = 4'd9;
    localparam logic [3:0] DONE   = 4'd10;

    localparam logic [3:0] PH_LAST   = 4'(PH_LEN - 1);
    localparam logic [3:0] STEP_LAST = 4'(MAX_STEP - 1);
    localparam logic [3:0] GOAL      = 4'(GOAL_ST);

    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic [3:0] phase_reg;
    logic [3:0] phase_next;
    logic       stall_eff;

`ifdef BWD_STALL_EN
    assign stall_eff = stall;
`else
    logic unused_stall;
    assign unused_stall = stall;
    assign stall_eff    = 1'b0;
`endif

    assign controller = state_reg;

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = QT;
                    phase_next = 4'd0;
                end
            end
            QT, MAXQ, DELTA3, DELTA2, GRAD: begin
                if (!stall_eff) begin
                    if (phase_reg == PH_LAST) begin
                        phase_next = 4'd0;
                        case (state_reg)
                            QT:      state_next = MAXQ;
                            MAXQ:    state_next = DELTA3;
                            DELTA3:  state_next = DELTA2;
                            DELTA2:  state_next = GRAD;
                            default: state_next = DONE;
                        endcase
                    end else begin
                        phase_next = phase_reg + 4'd1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                phase_next = 4'd0;
            end
            // Unused encodings fall back to IDLE rather than lock up.
            default: begin
                state_next = IDLE;
                phase_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            phase_reg  <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            grad_valid <= 1'b0;
            step       <= 4'd0;
            act        <= 2'd0;
            st         <= 4'd0;
            st1        <= 4'd0;
        end else begin
            state_reg  <= state_next;
            phase_reg  <= phase_next;
            busy       <= (state_next != IDLE);
            done       <= (state_next == DONE);
            grad_valid <= (state_next == GRAD) && (phase_next == PH_LAST);
            if ((state_reg == IDLE) && start) begin
                act <= act_in;
                st  <= st_in;
                st1 <= st1_in;
            end
            // Step advances only when a pass actually completes; goal ends the episode.
            if (state_reg == DONE) begin
                if (st1 == GOAL) begin
                    step <= 4'd0;
                end else if (step == STEP_LAST) begin
                    step <= 4'd0;
                end else begin
                    step <= step + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_backward_sequencer.sv
// Randomized and directed bench for backward_sequencer against a schedule-queue reference model.
`timescale 1ns/1ps
module tb_backward_sequencer;

    localparam int PH_LEN   = 2;
    localparam int MAX_STEP = 4;
    localparam int GOAL_ST  = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] act_in = 2'd0;
    logic [3:0] st_in = 4'd0;
    logic [3:0] st1_in = 4'd0;
    logic       stall = 1'b0;
    logic       busy, done, grad_valid;
    logic [3:0] controller, step, st, st1;
    logic [1:0] act;

    int check_cnt = 0;
    int fail_cnt  = 0;

    backward_sequencer #(.PH_LEN(PH_LEN), .MAX_STEP(MAX_STEP), .GOAL_ST(GOAL_ST)) dut (
        .clk(clk), .rst(rst), .start(start), .act_in(act_in), .st_in(st_in),
        .st1_in(st1_in), .stall(stall), .busy(busy), .done(done),
        .grad_valid(grad_valid), .controller(controller), .step(step),
        .act(act), .st(st), .st1(st1)
    );

    always #5 clk = ~clk;

    // Reference: on start, the whole pass is laid out as a queue of phase codes.
    int q[$];
    int cur = 0;
    int m_step = 0;
    int m_act = 0;
    int m_st = 0;
    int m_st1 = 0;
    int phase_codes[5] = '{1, 6, 7, 8, 9};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            cur = 0; m_step = 0; m_act = 0; m_st = 0; m_st1 = 0;
        end else if (cur == 0) begin
            if (start) begin
                m_act = int'(act_in); m_st = int'(st_in); m_st1 = int'(st1_in);
                q.delete();
                foreach (phase_codes[i])
                    for (int r = 0; r < PH_LEN; r++) q.push_back(phase_codes[i]);
                q.push_back(10);
                cur = q.pop_front();
            end
        end else if (cur != 10 && stall_on()) begin
            cur = cur;
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else begin
            cur = 0;
            m_step = (m_st1 == GOAL_ST) ? 0 : (m_step + 1) % MAX_STEP;
        end
    end

    function automatic bit stall_on();
`ifdef BWD_STALL_EN
        return stall;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_value(input string tag, input int got, input int exp);
        check_cnt++;
        if (got != exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        int exp_gv;
        @(negedge clk);
        exp_gv = (cur == 9 && q.size() > 0 && q[0] == 10) ? 1 : 0;
        check_value("controller", int'(controller), cur);
        check_value("busy", int'(busy), (cur != 0) ? 1 : 0);
        check_value("done", int'(done), (cur == 10) ? 1 : 0);
        check_value("grad_valid", int'(grad_valid), exp_gv);
        check_value("step", int'(step), m_step);
        check_value("act", int'(act), m_act);
        check_value("st", int'(st), m_st);
        check_value("st1", int'(st1), m_st1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Issues one start and waits (bounded) for done; returns the done cycle.
    task automatic run_pass(input int a, input int s, input int s1, output int done_cyc);
        done_cyc = -1;
        act_in = 2'(a); st_in = 4'(s); st1_in = 4'(s1); start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n < 60; n++) begin
            if (done) begin
                done_cyc = n;
                break;
            end
            tick();
        end
        if (done_cyc < 0) check_value("done_timeout", 0, 1);
        tick();
        $display("pass act=%0d st=%0d st1=%0d done_cycle=%0d step=%0d", a, s, s1, done_cyc, step);
    endtask

    initial begin
        int exp_ctrl[11] = '{1, 1, 6, 6, 7, 7, 8, 8, 9, 9, 10};
        int exp_wrap[4]  = '{1, 2, 3, 0};
        int dc, c6, ndone;

        // Reset state and idle behaviour with a mid-idle reset pulse.
        tick();
        check_value("rst_busy", int'(busy), 0);
        check_value("rst_ctrl", int'(controller), 0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_value("idle_busy", int'(busy), 0);
            check_value("idle_step", int'(step), 0);
        end
        $display("reset/idle checked");

        // Single pass with fixed cycle-by-cycle expectations.
        act_in = 2'd2; st_in = 4'd3; st1_in = 4'd4; start = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i == 1) start = 1'b0;
            check_value("seq_ctrl", int'(controller), exp_ctrl[i-1]);
            check_value("seq_gv", int'(grad_valid), (i == 10) ? 1 : 0);
            check_value("seq_done", int'(done), (i == 11) ? 1 : 0);
        end
        tick();
        check_value("seq_step", int'(step), 1);
        check_value("seq_act", int'(act), 2);
        check_value("seq_st", int'(st), 3);
        check_value("seq_st1", int'(st1), 4);
        $display("single pass step=%0d act=%0d st=%0d st1=%0d", step, act, st, st1);

        // start held high: only accepted in IDLE, one done every 12 cycles.
        ndone = 0;
        start = 1'b1;
        for (int i = 1; i <= 36; i++) begin
            st_in = 4'($urandom_range(0, 15));
            tick();
            if (done) ndone++;
        end
        start = 1'b0;
        check_value("busy_reject_dones", ndone, 3);
        $display("busy rejection done_count=%0d", ndone);
        for (int i = 0; i < 3; i++) tick();

        // Step wrap then goal-state episode end.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            run_pass(1, p, 5, dc);
            check_value("wrap_step", int'(step), exp_wrap[p]);
            check_value("wrap_latency", dc, 11);
        end
        run_pass(0, 1, 5, dc);
        run_pass(0, 2, 5, dc);
        check_value("pre_goal_step", int'(step), 2);
        run_pass(3, 7, 15, dc);
        check_value("goal_step", int'(step), 0);

        // Asynchronous reset in DELTA3 aborts the pass.
        act_in = 2'd1; st_in = 4'd9; st1_in = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 2; i <= 5; i++) tick();
        check_value("pre_abort_ctrl", int'(controller), 7);
        rst = 1'b0;
        #1;
        check_value("abort_busy", int'(busy), 0);
        check_value("abort_ctrl", int'(controller), 0);
        check_value("abort_step", int'(step), 0);
        check_value("abort_st", int'(st), 0);
        $display("mid-pass reset busy=%0d controller=%0d", busy, controller);
        tick();
        check_value("abort_no_done", int'(done), 0);
        rst = 1'b1;
        run_pass(2, 4, 6, dc);
        check_value("after_abort_step", int'(step), 1);
        check_value("after_abort_latency", dc, 11);

        // Stall during MAXQ for three cycles.
        act_in = 2'd3; st_in = 4'd5; st1_in = 4'd6; start = 1'b1;
        dc = -1; c6 = 0;
        for (int n = 1; n < 40; n++) begin
            tick();
            if (n == 1) start = 1'b0;
            if (controller == 4'd6) c6++;
            if (done) begin
                dc = n;
                break;
            end
            if (n == 3) stall = 1'b1;
            if (n == 6) stall = 1'b0;
        end
        stall = 1'b0;
        tick();
`ifdef BWD_STALL_EN
        check_value("stall_maxq_cycles", c6, 5);
        check_value("stall_done_cycle", dc, 14);
`else
        check_value("stall_maxq_cycles", c6, 2);
        check_value("stall_done_cycle", dc, 11);
`endif
        $display("stall pass maxq_cycles=%0d done_cycle=%0d", c6, dc);

        // Randomized traffic, including stalls, goal states and reset pulses.
        for (int i = 0; i < 600; i++) begin
            start  = ($urandom_range(0, 2) == 0);
            act_in = 2'($urandom_range(0, 3));
            st_in  = 4'($urandom_range(0, 15));
            st1_in = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            stall  = ($urandom_range(0, 3) == 0);
            rst    = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        tick();
        $display("random phase done");

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule
